// File: rtl/secded_stream_dec.sv
// Streaming extended-Hamming (SECDED) decoder: two-stage valid/ready pipeline
// with optional single-bit correction and saturating error statistics.
module secded_stream_dec #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16,
    localparam int P      = (DATA_W == 4)  ? 3 :
                            (DATA_W == 11) ? 4 :
                            (DATA_W == 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sgl,
    output logic              out_dbl,
    output logic [P-1:0]      out_syn,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_words,
    output logic [CNT_W-1:0]  cnt_sgl,
    output logic [CNT_W-1:0]  cnt_dbl
);

    generate
        if (!(DATA_W == 4 || DATA_W == 11 || DATA_W == 26 || DATA_W == 57)) begin : g_bad_data_w
            $error("secded_stream_dec: DATA_W must be 4, 11, 26 or 57");
        end
    endgenerate

    // Syndrome: XOR of the indices of every set bit above the overall-parity bit.
    function automatic logic [P-1:0] calc_syn(input logic [CODE_W-1:0] code);
        logic [P-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[i]) begin
                s = s ^ P'(i);
            end
        end
        return s;
    endfunction

    // Payload sits LSB-first in every position that is not a power of two.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 0;
        for (int i = 3; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = code[i];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [P-1:0]      s1_syn;
    logic              s1_q;
    logic              s1_corr;

    logic              s2_adv;
    logic              out_xfer;

    logic              s2_sgl_d;
    logic              s2_dbl_d;
    logic [CODE_W-1:0] s2_flip_d;
    logic [DATA_W-1:0] s2_data_d;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_q     <= 1'b0;
            s1_corr  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= calc_syn(in_code);
                s1_q    <= ^in_code;
                s1_corr <= corr_en;
            end
        end
    end

    // A zero syndrome with odd parity flips bit 0, which never reaches the payload.
    always_comb begin
        s2_sgl_d  = s1_q;
        s2_dbl_d  = !s1_q && (s1_syn != '0);
        s2_flip_d = '0;
        if (s1_q && s1_corr) begin
            s2_flip_d = CODE_W'(1) << s1_syn;
        end
        s2_data_d = extract_data(s1_code ^ s2_flip_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sgl   <= 1'b0;
            out_dbl   <= 1'b0;
            out_syn   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s2_data_d;
                out_sgl  <= s2_sgl_d;
                out_dbl  <= s2_dbl_d;
                out_syn  <= s1_syn;
            end
        end
    end

    // Clear beats a same-cycle transfer; reset beats both.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            cnt_words <= '0;
            cnt_sgl   <= '0;
            cnt_dbl   <= '0;
        end else if (out_xfer) begin
            cnt_words <= sat_inc(cnt_words);
            if (out_sgl) begin
                cnt_sgl <= sat_inc(cnt_sgl);
            end
            if (out_dbl) begin
                cnt_dbl <= sat_inc(cnt_dbl);
            end
        end
    end

endmodule

// File: tb/tb_secded_stream_dec.sv
// Directed bench for secded_stream_dec: DATA_W=11 main instance plus a
// CNT_W=2 instance for counter saturation.
module tb_secded_stream_dec;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_code;
    logic        corr_en;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic        out_sgl;
    logic        out_dbl;
    logic [3:0]  out_syn;
    logic        clr_cnt;
    logic [15:0] cnt_words;
    logic [15:0] cnt_sgl;
    logic [15:0] cnt_dbl;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_code;
    logic        s_corr_en;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [10:0] s_out_data;
    logic        s_out_sgl;
    logic        s_out_dbl;
    logic [3:0]  s_out_syn;
    logic        s_clr_cnt;
    logic [1:0]  s_cnt_words;
    logic [1:0]  s_cnt_sgl;
    logic [1:0]  s_cnt_dbl;

    int n_checks;
    int n_fail;

    secded_stream_dec #(.DATA_W(11), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sgl(out_sgl), .out_dbl(out_dbl), .out_syn(out_syn),
        .clr_cnt(clr_cnt), .cnt_words(cnt_words), .cnt_sgl(cnt_sgl), .cnt_dbl(cnt_dbl)
    );

    secded_stream_dec #(.DATA_W(11), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_code(s_in_code), .corr_en(s_corr_en),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_sgl(s_out_sgl), .out_dbl(s_out_dbl), .out_syn(s_out_syn),
        .clr_cnt(s_clr_cnt), .cnt_words(s_cnt_words), .cnt_sgl(s_cnt_sgl), .cnt_dbl(s_cnt_dbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: payload into non-power-of-two slots, then parity bits.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int          j;
        c = '0;
        j = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            logic p;
            p = 1'b0;
            for (int i = 1; i < 16; i++) begin
                if (((i >> k) & 1) == 1) p = p ^ c[i];
            end
            c[1 << k] = p;
        end
        c[0] = ^c;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_code = '0; corr_en = 1'b1; out_ready = 1'b1; clr_cnt = 1'b0;
        s_in_valid = 1'b0; s_in_code = '0; s_corr_en = 1'b1; s_out_ready = 1'b1; s_clr_cnt = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({out_valid, out_data, out_sgl, out_dbl, out_syn} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {out_valid, out_data, out_sgl, out_dbl, out_syn});
        end
        n_checks++;
        if ({cnt_words, cnt_sgl, cnt_dbl, s_cnt_words, s_cnt_sgl, s_cnt_dbl} !== 54'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h/%h/%h want 0", cnt_words, cnt_sgl, cnt_dbl);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: in_ready/out_valid got %b%b want 10", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] codes [11] = '{16'h0000, 16'hFFFF, 16'h0008, 16'h0008, 16'h0001, 16'h0006,
                                    16'hFFEF, 16'h7FFF, 16'h7FFF, 16'hFFFC, 16'hFFD7};
        logic        corrs [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        // {data, sgl, dbl, syn}
        logic [16:0] exps [11] = '{{11'h000, 1'b0, 1'b0, 4'd0},
                                   {11'h7FF, 1'b0, 1'b0, 4'd0},
                                   {11'h000, 1'b1, 1'b0, 4'd3},
                                   {11'h001, 1'b1, 1'b0, 4'd3},
                                   {11'h000, 1'b1, 1'b0, 4'd0},
                                   {11'h000, 1'b0, 1'b1, 4'd3},
                                   {11'h7FF, 1'b1, 1'b0, 4'd4},
                                   {11'h7FF, 1'b1, 1'b0, 4'd15},
                                   {11'h3FF, 1'b1, 1'b0, 4'd15},
                                   {11'h7FF, 1'b0, 1'b1, 4'd1},
                                   {11'h7FC, 1'b0, 1'b1, 4'd6}};
        out_ready = 1'b1;
        for (int v = 0; v < 11; v++) begin
            in_valid = 1'b1;
            in_code  = codes[v];
            corr_en  = corrs[v];
            tick();
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_latency: out_valid got %b want 0 one cycle after accept", v, out_valid);
            end
            tick();
            n_checks++;
            if ({out_valid, out_data, out_sgl, out_dbl, out_syn} !== {1'b1, exps[v]}) begin
                n_fail++;
                $display("FAIL vec%0d_result: got v=%b d=%h s=%b d=%b syn=%0d want d=%h flags/syn=%b",
                         v, out_valid, out_data, out_sgl, out_dbl, out_syn, exps[v][16:6], exps[v][5:0]);
            end
        end
        tick();
        n_checks++;
        if ({cnt_words, cnt_sgl, cnt_dbl} !== {16'd11, 16'd6, 16'd3}) begin
            n_fail++;
            $display("FAIL vec_counters: got %0d/%0d/%0d want 11/6/3", cnt_words, cnt_sgl, cnt_dbl);
        end
    endtask

    task automatic test_back_to_back();
        int          pa [15] = '{-1, 3, -1, 9, 3, 0, -1, 8, -1, 3, 3, -1, 15, 5, -1};
        int          pb [15] = '{-1, -1, -1, -1, 5, -1, -1, -1, -1, 5, -1, -1, -1, -1, -1};
        logic        cr [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] codes [15];
        logic [16:0] exps [15];
        logic [16:0] obs;
        logic [16:0] held;
        logic [10:0] d;
        logic        stalled;
        int          sent, rcvd, cyc;

        for (int i = 0; i < 15; i++) begin
            d = 11'(i * 309 + 7);
            codes[i] = encode(d);
            if (pa[i] >= 0) codes[i][pa[i]] = ~codes[i][pa[i]];
            if (pb[i] >= 0) codes[i][pb[i]] = ~codes[i][pb[i]];
            if (pb[i] >= 0)
                exps[i] = {d ^ 11'h003, 1'b0, 1'b1, 4'd6};
            else if (pa[i] >= 0 && !cr[i])
                exps[i] = {d ^ ((pa[i] == 3) ? 11'h001 : 11'h400), 1'b1, 1'b0, 4'(pa[i])};
            else if (pa[i] >= 0)
                exps[i] = {d, 1'b1, 1'b0, 4'(pa[i])};
            else
                exps[i] = {d, 1'b0, 1'b0, 4'd0};
        end

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;

        sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (rcvd < 15 && cyc < 100) begin
            in_valid = (sent < 15);
            if (sent < 15) begin
                in_code = codes[sent];
                corr_en = cr[sent];
            end
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            obs = {out_data, out_sgl, out_dbl, out_syn};
            if (stalled) begin
                n_checks++;
                if ({out_valid, obs} !== {1'b1, held}) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc%0d: got v=%b %h want v=1 %h", cyc, out_valid, obs, held);
                end
            end
            stalled = out_valid && !out_ready;
            held    = obs;
            if (out_valid && out_ready) begin
                n_checks++;
                if (obs !== exps[rcvd]) begin
                    n_fail++;
                    $display("FAIL stream_word%0d: got %h want %h", rcvd, obs, exps[rcvd]);
                end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (rcvd != 15) begin
            n_fail++;
            $display("FAIL stream_timeout: received %0d words want 15", rcvd);
        end
        n_checks++;
        if ({cnt_words, cnt_sgl, cnt_dbl} !== {16'd15, 16'd7, 16'd2}) begin
            n_fail++;
            $display("FAIL stream_counters: got %0d/%0d/%0d want 15/7/2", cnt_words, cnt_sgl, cnt_dbl);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        corr_en   = 1'b1;
        in_valid  = 1'b1;
        in_code   = 16'h0008;
        tick();
        in_code   = 16'h0006;
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL midreset_setup: out_valid/in_ready got %b%b want 10", out_valid, in_ready);
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_data, out_sgl, out_dbl, out_syn, cnt_words, cnt_sgl, cnt_dbl} !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got v=%b d=%h cnt=%0d/%0d/%0d want all 0",
                     out_valid, out_data, cnt_words, cnt_sgl, cnt_dbl);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: in_ready got %b want 1", in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if ({out_valid, cnt_words} !== 17'h0) begin
                n_fail++;
                $display("FAIL midreset_late%0d: out_valid=%b cnt_words=%0d want 0/0", c, out_valid, cnt_words);
            end
        end
    endtask

    task automatic test_clr_on_transfer();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 16'h0008;
        corr_en   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clr_cnt = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, cnt_words, cnt_sgl} !== {1'b1, 16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL clr_setup: out_valid=%b cnt=%0d/%0d want 1 and 1/1", out_valid, cnt_words, cnt_sgl);
        end
        tick();
        clr_cnt = 1'b0;
        n_checks++;
        if ({out_valid, cnt_words, cnt_sgl, cnt_dbl} !== 49'h0) begin
            n_fail++;
            $display("FAIL clr_wins: out_valid=%b cnt=%0d/%0d/%0d want 0 and 0/0/0",
                     out_valid, cnt_words, cnt_sgl, cnt_dbl);
        end
    endtask

    task automatic test_saturate();
        s_out_ready = 1'b1;
        s_corr_en   = 1'b1;
        s_in_code   = 16'h0008;
        s_in_valid  = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 4) begin
                n_checks++;
                if ({s_cnt_words, s_cnt_sgl} !== {2'd2, 2'd2}) begin
                    n_fail++;
                    $display("FAIL sat_midway: got %0d/%0d want 2/2", s_cnt_words, s_cnt_sgl);
                end
            end
        end
        s_in_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({s_cnt_words, s_cnt_sgl, s_cnt_dbl, s_out_valid} !== {2'd3, 2'd3, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d/%0d/%0d v=%b want 3/3/0 v=0",
                     s_cnt_words, s_cnt_sgl, s_cnt_dbl, s_out_valid);
        end
        s_in_valid = 1'b1;
        s_in_code  = 16'h0006;
        tick();
        s_in_valid = 1'b0;
        tick();
        s_clr_cnt = 1'b1;
        tick();
        s_clr_cnt = 1'b0;
        n_checks++;
        if ({s_cnt_words, s_cnt_sgl, s_cnt_dbl} !== 6'h0) begin
            n_fail++;
            $display("FAIL sat_clr: got %0d/%0d/%0d want 0/0/0", s_cnt_words, s_cnt_sgl, s_cnt_dbl);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midstream();
        test_clr_on_transfer();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/secded_stream_dec.md
SECDED_STREAM_DEC -- requirements
Module: secded_stream_dec

Interface
REQ-001 The block SHALL have parameter DATA_W, default 11, giving payload bits per word; legal values are 4, 11, 26 and 57, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each statistics counter.
REQ-003 The block SHALL derive localparams: P = Hamming parity count (3/4/5/6); CODE_W = DATA_W+P+1 (8/16/32/64).
REQ-004 Ports, in this order:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword present.
- in_ready  out  1  block accepts codeword this cycle.
- in_code  in  CODE_W  codeword: bit 0 = overall parity p0; bit 2^k = parity pk; remaining positions = data LSB-first.
- corr_en  in  1  1 = correct single errors; 0 = detect only; sampled with in_code.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  decoded payload.
- out_sgl  out  1  single error detected.
- out_dbl  out  1  double error detected.
- out_syn  out  P  syndrome.
- clr_cnt  in  1  clear all counters.
- cnt_words / cnt_sgl / cnt_dbl  out  CNT_W each  words retired / single errors / double errors.

Function
REQ-005 The block SHALL be a 2-stage pipeline. S1 registers the input code, syndrome, overall parity and corr_en. S2 registers the corrected data and flags.
REQ-006 A transfer SHALL occur only on a cycle with valid&ready high on that side.
REQ-007 With out_ready held high, a word accepted in cycle N SHALL appear on the outputs in cycle N+2; throughput SHALL be 1 word/cycle.
REQ-008 Each stage SHALL advance when it is empty or when the stage after it advances. in_ready SHALL equal !S1_valid | S1_advance; it SHALL depend combinationally on out_ready only.
REQ-009 While out_valid=1 and out_ready=0, all out_* signals SHALL be held stable, and no word SHALL be dropped or duplicated.
REQ-010 Syndrome s SHALL be the XOR of the position indices of all set bits in in_code[CODE_W-1:1]. Overall parity q SHALL be the XOR of all CODE_W bits.
REQ-011 Classification:
- s=0, q=0: no error; sgl=0, dbl=0.
- q=1: single error; sgl=1, dbl=0. This includes s=0, which means p0 flipped; data is unchanged in that case.
- s!=0, q=0: double error; sgl=0, dbl=1.
REQ-012 On a single error with corr_en=1, bit s SHALL be inverted before data extraction. With corr_en=0, raw data SHALL pass through, while flags and syndrome are still reported.
REQ-013 On a double error, out_data SHALL be the raw, uncorrected extracted data.
REQ-014 A single error located on a parity position SHALL leave out_data equal to the raw data.
REQ-015 out_syn SHALL always report s, including for double errors.
REQ-016 Counters SHALL increment on each output transfer: cnt_words always; cnt_sgl when sgl=1; cnt_dbl when dbl=1.
REQ-017 Each counter SHALL saturate at all-ones and never wrap.
REQ-018 clr_cnt SHALL zero all counters on the next edge; a transfer in the same cycle SHALL NOT be counted, so clear wins.
REQ-019 corr_en SHALL travel with its word; a change mid-stream SHALL affect only words accepted after the change.

Reset
REQ-020 While reset=1, the block SHALL force the following on the next edge:
- S1/S2 valid = 0, so out_valid = 0;
- out_data, out_sgl, out_dbl, out_syn = 0;
- all counters = 0.
REQ-021 in_ready SHALL be 1 on the cycle after reset deasserts.
REQ-022 Reset asserted mid-stream SHALL discard in-flight words without emitting them and without updating counters.
REQ-023 Reset SHALL take priority over clr_cnt and over any handshake in the same cycle.

Verification (DATA_W=11, out_ready=1 unless stated)
REQ-024 Input 16'h0000, corr_en=1 -> two cycles later: data 11'h000, sgl=0, dbl=0, syn=0. Input 16'hFFFF -> data 11'h7FF, flags 0.
REQ-025 Input 16'h0008 (bit 3 flipped), corr_en=1 -> data 11'h000, sgl=1, syn=3. Same input with corr_en=0 -> data 11'h001, sgl=1.
REQ-026 Input 16'h0001 (p0 flipped) -> data 11'h000, sgl=1, dbl=0, syn=0. Input 16'h0006 (bits 1 and 2 flipped) -> dbl=1, sgl=0, syn=3, data 11'h000.
REQ-027 Back-to-back stream of 15 words, out_ready low for 3 cycles mid-stream:
- outputs held stable while stalled;
- all 15 results emitted in order;
- cnt_words=15.
REQ-028 CNT_W=2 with 5 single-error words -> cnt_sgl saturates at 3. clr_cnt asserted on a transfer cycle -> all counters read 0 on the next cycle.
REQ-029 Reset asserted with 2 words in flight -> out_valid=0 next cycle, counters 0, no late emission.
